// File: rtl/mux_2_to_1.sv
// mux_2_to_1: two-input datapath selector with enable and optional output register.
//
// Forwards a (se = 0) or b (se = 1) to y while en is high. When en is low, y is
// driven to DIS_VAL (truncated to WIDTH bits) regardless of se. en takes priority.
//
// Parameters:
//   WIDTH   - data width of a, b and y (1..64).
//   REG_OUT - 1: y is registered on clk (1 cycle latency, async reset to 0).
//             0: y is purely combinational; clk and rst are ignored.
//   DIS_VAL - value driven on y while disabled; only the low WIDTH bits are used.
//
// Ports:
//   clk - rising-edge clock for the output register.
//   rst - asynchronous active-high reset; clears the output register to all zeros.
//   a   - data input 0.
//   b   - data input 1.
//   se  - select.
//   en  - active-high enable.
//   y   - selected data, or DIS_VAL when disabled.
module mux_2_to_1 #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REG_OUT = 1,
  parameter logic [63:0] DIS_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             se,
  input  logic             en,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] DisVal = DIS_VAL[WIDTH-1:0];

  // Next-value function shared by both output styles.
  logic [WIDTH-1:0] y_d;

  always_comb begin
    y_d = DisVal;
    if (en) begin
      y_d = se ? b : a;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] y_q;

    // Reset value is all zeros, deliberately independent of DIS_VAL.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign y = y_q;
  end else begin : g_comb_out
    // clk/rst intentionally unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign y = y_d;
  end

endmodule

// File: tb/tb_mux_2_to_1.sv
module tb_mux_2_to_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=1 registered pair, sharing inputs; DIS_VAL 0 and 1.
  logic a1, b1, se1, en1;
  logic y1_dv0, y1_dv1;

  // WIDTH=8 combinational.
  logic [7:0] a8, b8, y8;
  logic       se8, en8;

  // WIDTH=16 registered.
  logic [15:0] a16, b16, y16;
  logic        se16, en16;

  mux_2_to_1 #(.WIDTH(1), .REG_OUT(1), .DIS_VAL(64'd0)) u_w1_dv0 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .se(se1), .en(en1), .y(y1_dv0)
  );

  mux_2_to_1 #(.WIDTH(1), .REG_OUT(1), .DIS_VAL(64'd1)) u_w1_dv1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .se(se1), .en(en1), .y(y1_dv1)
  );

  mux_2_to_1 #(.WIDTH(8), .REG_OUT(0), .DIS_VAL(64'd0)) u_w8_comb (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .se(se8), .en(en8), .y(y8)
  );

  mux_2_to_1 #(.WIDTH(16), .REG_OUT(1), .DIS_VAL(64'h0000_0000_0000_BEEF)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .se(se16), .en(en16), .y(y16)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboards: expected values pushed when stimulus is driven.
  logic [15:0] sb_dv0[$];
  logic [15:0] sb_dv1[$];
  logic [15:0] sb_w8[$];
  logic [15:0] sb_w16[$];

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic se, input logic en,
                                        input logic [15:0] dis);
    if (!en) return dis;
    return se ? b : a;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the WIDTH=1 pair at a falling edge, compare just after the next rising edge.
  task automatic step_w1(input string tag, input logic a, input logic b,
                         input logic se, input logic en);
    @(negedge clk);
    a1 = a; b1 = b; se1 = se; en1 = en;
    sb_dv0.push_back(model({15'd0, a}, {15'd0, b}, se, en, 16'd0));
    sb_dv1.push_back(model({15'd0, a}, {15'd0, b}, se, en, 16'd1));
    @(posedge clk);
    #1;
    check({tag, "_dv0"}, {15'd0, y1_dv0}, sb_dv0.pop_front());
    check({tag, "_dv1"}, {15'd0, y1_dv1}, sb_dv1.pop_front());
  endtask

  // Combinational DUT: expected value is due one delta-settle after driving.
  task automatic step_w8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic se, input logic en);
    a8 = a; b8 = b; se8 = se; en8 = en;
    sb_w8.push_back(model({8'd0, a}, {8'd0, b}, se, en, 16'd0));
    #1;
    check(tag, {8'd0, y8}, sb_w8.pop_front());
  endtask

  initial begin
    a1 = 1'b0; b1 = 1'b0; se1 = 1'b0; en1 = 1'b0;
    a8 = '0; b8 = '0; se8 = 1'b0; en8 = 1'b0;
    a16 = '0; b16 = '0; se16 = 1'b0; en16 = 1'b0;
    rst = 1'b1;

    // Reset state: zero for every registered build, even with nonzero DIS_VAL.
    #2;
    check("rst_w1_dv0", {15'd0, y1_dv0}, 16'd0);
    check("rst_w1_dv1", {15'd0, y1_dv1}, 16'd0);
    check("rst_w16", y16, 16'd0);

    // Combinational build ignores clk/rst; exercise it while rst is high.
    step_w8("w8_sel_a", 8'hA5, 8'h3C, 1'b0, 1'b1);
    step_w8("w8_sel_b", 8'hA5, 8'h3C, 1'b1, 1'b1);
    step_w8("w8_dis", 8'hA5, 8'h3C, 1'b1, 1'b0);
    step_w8("w8_dis_se0", 8'hA5, 8'h3C, 1'b0, 1'b0);
    step_w8("w8_sel_a2", 8'h5A, 8'hFF, 1'b0, 1'b1);

    // rst held across an edge keeps y at zero.
    @(posedge clk);
    #1;
    check("rst_hold_w16", y16, 16'd0);

    @(negedge clk);
    rst = 1'b0;

    // Select a.
    step_w1("sel_a_00", 1'b0, 1'b0, 1'b0, 1'b1);
    step_w1("sel_a_01", 1'b0, 1'b1, 1'b0, 1'b1);
    step_w1("sel_a_10", 1'b1, 1'b0, 1'b0, 1'b1);
    // Select b.
    step_w1("sel_b_10", 1'b1, 1'b0, 1'b1, 1'b1);
    step_w1("sel_b_01", 1'b0, 1'b1, 1'b1, 1'b1);
    // Disable overrides se.
    step_w1("dis_11", 1'b1, 1'b1, 1'b1, 1'b0);
    step_w1("dis_se0", 1'b1, 1'b1, 1'b0, 1'b0);
    // se and en change together.
    step_w1("both_chg", 1'b0, 1'b1, 1'b1, 1'b1);

    // Mid-cycle input change must not reach the registered output.
    step_w1("pre_mid", 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    a1 = 1'b0;
    #1;
    check("mid_cycle_dv0", {15'd0, y1_dv0}, 16'd1);

    // Reset mid-operation: y clears immediately, recovers at the next edge.
    step_w1("hold_a1", 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dv0", {15'd0, y1_dv0}, 16'd0);
    check("async_rst_dv1", {15'd0, y1_dv1}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_dv0", {15'd0, y1_dv0}, 16'd1);

    // Random sweep on the 16-bit registered build.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      se16 = 1'($urandom);
      en16 = ($urandom_range(0, 3) != 0);
      sb_w16.push_back(model(a16, b16, se16, en16, 16'hBEEF));
      @(posedge clk);
      #1;
      check("w16_rand", y16, sb_w16.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
